// File: rtl/dmux8way16_dispatch_if.sv
// Producer/consumer bundle for dmux8way16_dispatch. Define DMUX8WAY16_BROADCAST_EN to add in_bcast.
interface dmux8way16_dispatch_if #(
   parameter int WIDTH = 16,
   parameter int SEL_W = 3
) ();
   localparam int LANES = 2 ** SEL_W;

   logic [WIDTH-1:0]       in_data;
   logic [SEL_W-1:0]       in_sel;
   logic                   in_valid;
   logic                   in_ready;
`ifdef DMUX8WAY16_BROADCAST_EN
   logic                   in_bcast;
`endif
   logic [LANES*WIDTH-1:0] out_data;
   logic [LANES-1:0]       out_valid;
   logic [LANES-1:0]       out_ready;
   logic [SEL_W:0]         occupancy;
   logic [15:0]            accept_count;

   // master = producer/consumer side, slave = the dispatcher
   modport master (
      output in_data, in_sel, in_valid,
`ifdef DMUX8WAY16_BROADCAST_EN
      output in_bcast,
`endif
      input  in_ready,
      input  out_data, out_valid, occupancy, accept_count,
      output out_ready
   );

   modport slave (
      input  in_data, in_sel, in_valid,
`ifdef DMUX8WAY16_BROADCAST_EN
      input  in_bcast,
`endif
      output in_ready,
      output out_data, out_valid, occupancy, accept_count,
      input  out_ready
   );
endinterface

// File: rtl/dmux8way16_dispatch.sv
// 1-to-8 word dispatcher into single-entry lane buffers, each drained over valid/ready.
// Optional broadcast to all lanes when DMUX8WAY16_BROADCAST_EN is defined.
module dmux8way16_dispatch #(
   parameter int WIDTH = 16,
   parameter int SEL_W = 3
) (
   input logic clk,
   input logic reset,
   dmux8way16_dispatch_if.slave bus
);
   localparam int LANES = 2 ** SEL_W;

   // Handshake: a transfer happens on a rising edge where valid && ready; the
   // sender holds its payload stable until then, ready never depends on valid.
   logic [WIDTH-1:0] data_q [LANES];
   logic [LANES-1:0] valid_q;
   logic [SEL_W:0]   occ_q;
   logic [15:0]      count_q;

   logic [LANES-1:0] lane_free;
   logic [LANES-1:0] load;
   logic [LANES-1:0] valid_next;
   logic [SEL_W:0]   occ_next;
   logic             bcast;
   logic             accept;

`ifdef DMUX8WAY16_BROADCAST_EN
   assign bcast = bus.in_bcast;
`else
   assign bcast = 1'b0;
`endif

   assign lane_free   = ~valid_q | bus.out_ready;
   assign bus.in_ready = bcast ? (&lane_free) : lane_free[bus.in_sel];
   assign accept      = bus.in_valid && bus.in_ready;

   always_comb begin
      load       = '0;
      valid_next = '0;
      occ_next   = '0;
      for (int k = 0; k < LANES; k++) begin
         load[k]       = accept && (bcast || (bus.in_sel == SEL_W'(k)));
         // A drain and an accept on the same edge keep the lane full.
         valid_next[k] = load[k] || (valid_q[k] && !bus.out_ready[k]);
         occ_next      = occ_next + (SEL_W + 1)'(valid_next[k]);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= '0;
         occ_q   <= '0;
         count_q <= '0;
         for (int k = 0; k < LANES; k++) data_q[k] <= '0;
      end else begin
         valid_q <= valid_next;
         occ_q   <= occ_next;
         if (accept) count_q <= count_q + 16'd1;
         for (int k = 0; k < LANES; k++)
            if (load[k]) data_q[k] <= bus.in_data;
      end
   end

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      assign bus.out_data[WIDTH*g +: WIDTH] = data_q[g];
   end

   assign bus.out_valid    = valid_q;
   assign bus.occupancy    = occ_q;
   assign bus.accept_count = count_q;
endmodule

// File: tb/tb_dmux8way16_dispatch.sv
// Directed bench for dmux8way16_dispatch: lane-array model checked every cycle plus literal checks.
module tb_dmux8way16_dispatch;
   localparam int WIDTH = 16;
   localparam int SEL_W = 3;
   localparam int LANES = 8;

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;
   bit   cmp_en = 1'b0;

   dmux8way16_dispatch_if #(.WIDTH(WIDTH), .SEL_W(SEL_W)) bus ();
   dmux8way16_dispatch #(.WIDTH(WIDTH), .SEL_W(SEL_W)) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   // clock / reset
   always #5 clk = ~clk;

   // model: one word slot per lane plus a full flag
   logic [WIDTH-1:0] m_data [LANES];
   bit               m_full [LANES];
   logic [15:0]      m_count;

   function automatic bit model_bcast();
`ifdef DMUX8WAY16_BROADCAST_EN
      return bus.in_bcast;
`else
      return 1'b0;
`endif
   endfunction

   function automatic bit model_ready();
      bit r;
      if (model_bcast()) begin
         r = 1'b1;
         for (int k = 0; k < LANES; k++)
            if (m_full[k] && !bus.out_ready[k]) r = 1'b0;
      end else begin
         r = !m_full[bus.in_sel] || bus.out_ready[bus.in_sel];
      end
      return r;
   endfunction

   always @(posedge clk) begin
      bit acc;
      if (reset) begin
         for (int k = 0; k < LANES; k++) begin
            m_data[k] = '0;
            m_full[k] = 1'b0;
         end
         m_count = 16'd0;
      end else begin
         acc = bus.in_valid && model_ready();
         for (int k = 0; k < LANES; k++)
            if (m_full[k] && bus.out_ready[k]) m_full[k] = 1'b0;
         if (acc) begin
            m_count = m_count + 16'd1;
            for (int k = 0; k < LANES; k++)
               if (model_bcast() || bus.in_sel == 3'(k)) begin
                  m_data[k] = bus.in_data;
                  m_full[k] = 1'b1;
               end
         end
      end
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // scoreboard: compare every cycle on the falling edge
   always @(negedge clk) begin
      logic [LANES-1:0] ev;
      int occ;
      if (cmp_en) begin
         ev  = '0;
         occ = 0;
         for (int k = 0; k < LANES; k++) begin
            ev[k] = m_full[k];
            if (m_full[k]) occ++;
            chk($sformatf("lane%0d_data", k), 128'(bus.out_data[WIDTH*k +: WIDTH]), 128'(m_data[k]));
         end
         chk("out_valid", 128'(bus.out_valid), 128'(ev));
         chk("occupancy", 128'(bus.occupancy), 128'(occ));
         chk("accept_count", 128'(bus.accept_count), 128'(m_count));
         chk("in_ready", 128'(bus.in_ready), 128'(model_ready()));
      end
   end

   // driver tasks
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic drive(input bit v, input logic [2:0] sel, input logic [15:0] d, input logic [7:0] rdy);
      bus.in_valid  = v;
      bus.in_sel    = sel;
      bus.in_data   = d;
      bus.out_ready = rdy;
   endtask

   function automatic logic [15:0] lane(input int k);
      return bus.out_data[WIDTH*k +: WIDTH];
   endfunction

   initial begin
      reset = 1'b1;
      drive(1'b0, 3'd0, 16'h0, 8'h00);
`ifdef DMUX8WAY16_BROADCAST_EN
      bus.in_bcast = 1'b0;
`endif
      step();
      cmp_en = 1'b1;
      step();
      reset = 1'b0;
      step();

      // idle after reset
      chk("rst_valid", 128'(bus.out_valid), 128'h00);
      chk("rst_occ", 128'(bus.occupancy), 128'd0);
      chk("rst_count", 128'(bus.accept_count), 128'd0);
      chk("rst_data", 128'(bus.out_data), 128'h0);
      for (int s = 0; s < LANES; s++) begin
         bus.in_sel = 3'(s);
         #1;
         chk($sformatf("rst_ready_sel%0d", s), 128'(bus.in_ready), 128'd1);
      end

      // accept 0x1234 into lane 5
      drive(1'b1, 3'd5, 16'h1234, 8'h00);
      step();
      drive(1'b0, 3'd5, 16'h0, 8'h00);
      #1;
      chk("l5_valid", 128'(bus.out_valid), 128'h20);
      chk("l5_data", 128'(lane(5)), 128'h1234);
      chk("l5_occ", 128'(bus.occupancy), 128'd1);

      // lane 5 full, not draining: stall
      drive(1'b1, 3'd5, 16'hBEEF, 8'h00);
      #1;
      chk("stall_ready", 128'(bus.in_ready), 128'd0);
      step();
      chk("stall_data", 128'(lane(5)), 128'h1234);
      chk("stall_count", 128'(bus.accept_count), 128'd1);

      // drain + accept on lane 5 same edge
      bus.out_ready = 8'h20;
      #1;
      chk("pass_ready", 128'(bus.in_ready), 128'd1);
      step();
      drive(1'b0, 3'd0, 16'h0, 8'h00);
      #1;
      chk("pass_valid", 128'(bus.out_valid), 128'h20);
      chk("pass_data", 128'(lane(5)), 128'hBEEF);
      chk("pass_count", 128'(bus.accept_count), 128'd2);

      // empty lane 5, then fill all lanes
      bus.out_ready = 8'h20;
      step();
      for (int k = 0; k < LANES; k++) begin
         drive(1'b1, 3'(k), 16'(k), 8'h00);
         step();
      end
      drive(1'b0, 3'd0, 16'h0, 8'h00);
      #1;
      chk("fill_valid", 128'(bus.out_valid), 128'hFF);
      chk("fill_occ", 128'(bus.occupancy), 128'd8);
      chk("fill_l7", 128'(lane(7)), 128'h0007);
      bus.out_ready = 8'h89;
      step();
      bus.out_ready = 8'h00;
      #1;
      chk("drain_valid", 128'(bus.out_valid), 128'h76);
      chk("drain_occ", 128'(bus.occupancy), 128'd5);
      chk("drain_l0_hold", 128'(lane(0)), 128'h0000);
      chk("drain_l3_hold", 128'(lane(3)), 128'h0003);

      // mixed directed traffic: drains, stalls, ready on empty lanes
      drive(1'b1, 3'd1, 16'hCAFE, 8'h06);   step();
      drive(1'b1, 3'd1, 16'hD00D, 8'h00);   step();
      drive(1'b1, 3'd0, 16'h1111, 8'h01);   step();
      drive(1'b0, 3'd4, 16'h2222, 8'hF0);   step();
      drive(1'b1, 3'd4, 16'h3333, 8'h00);   step();
      drive(1'b0, 3'd0, 16'h0, 8'hFF);      step();
      bus.out_ready = 8'h00;
      #1;
      chk("mix_valid", 128'(bus.out_valid), 128'h00);
      chk("mix_l1", 128'(lane(1)), 128'hCAFE);
      chk("mix_l4", 128'(lane(4)), 128'h3333);
      chk("mix_count", 128'(bus.accept_count), 128'd13);

      // counter wrap
      reset = 1'b1;
      step();
      reset = 1'b0;
      for (int i = 0; i < 65535; i++) begin
         drive(1'b1, 3'(i % 8), 16'(i), 8'hFF);
         step();
      end
      drive(1'b0, 3'd0, 16'h0, 8'hFF);
      #1;
      chk("wrap_ffff", 128'(bus.accept_count), 128'hFFFF);
      drive(1'b1, 3'd6, 16'h6666, 8'hFF);
      step();
      drive(1'b0, 3'd0, 16'h0, 8'h00);
      #1;
      chk("wrap_zero", 128'(bus.accept_count), 128'h0000);

      // reset beats a same-cycle accept
      reset = 1'b1;
      drive(1'b1, 3'd2, 16'h5555, 8'h00);
      step();
      reset = 1'b0;
      drive(1'b0, 3'd0, 16'h0, 8'h00);
      #1;
      chk("rstacc_valid", 128'(bus.out_valid), 128'h00);
      chk("rstacc_l2", 128'(lane(2)), 128'h0000);
      chk("rstacc_count", 128'(bus.accept_count), 128'd0);

`ifdef DMUX8WAY16_BROADCAST_EN
      bus.in_bcast = 1'b1;
      drive(1'b1, 3'd3, 16'hA5A5, 8'h00);
      step();
      drive(1'b0, 3'd0, 16'h0, 8'h00);
      #1;
      chk("bc_valid", 128'(bus.out_valid), 128'hFF);
      chk("bc_data", 128'(bus.out_data), {8{16'hA5A5}});
      chk("bc_count", 128'(bus.accept_count), 128'd1);
      chk("bc_ready_full", 128'(bus.in_ready), 128'd0);
      bus.in_bcast = 1'b0;
`endif

      step();
      cmp_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
